// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment display driver.
// It scans NUM_DIGITS digits one slot at a time, with CLK_DIV clocks per slot.
// New display data is double-buffered and swapped only at a frame boundary,
// so a single frame never shows a mix of old and new digits.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  input  logic                    lzs_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           index;
  logic                    tick;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] active_digits;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [NUM_DIGITS-1:0]   active_blank;
  logic [4*NUM_DIGITS-1:0] pending_digits;
  logic [NUM_DIGITS-1:0]   pending_dp;
  logic [NUM_DIGITS-1:0]   pending_blank;
  logic                    pending_valid;

  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              sel_nibble;
  logic                    dark;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  // Active-high hex font, bit0 = segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick = (prescaler == PRESC_LAST);
  assign wrap = tick && (index == INDEX_LAST);

  // Slot timer and digit index; the index steps once per full slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler <= '0;
      index     <= '0;
      frame_o   <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        index <= (index == INDEX_LAST) ? '0 : index + 1'b1;
      end
      frame_o <= wrap;
    end
  end

  // Double buffer: loads park in pending and move to active only at a wrap.
  // A load landing exactly on the wrap skips the pending stage altogether.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_digits  <= '0;
      active_dp      <= '0;
      active_blank   <= '0;
      pending_digits <= '0;
      pending_dp     <= '0;
      pending_blank  <= '0;
      pending_valid  <= 1'b0;
    end else if (load_i && wrap) begin
      active_digits <= digits_i;
      active_dp     <= dp_i;
      active_blank  <= blank_i;
      pending_valid <= 1'b0;
    end else begin
      if (wrap && pending_valid) begin
        active_digits <= pending_digits;
        active_dp     <= pending_dp;
        active_blank  <= pending_blank;
        pending_valid <= 1'b0;
      end
      if (load_i) begin
        pending_digits <= digits_i;
        pending_dp     <= dp_i;
        pending_blank  <= blank_i;
        pending_valid  <= 1'b1;
      end
    end
  end

  // Leading-zero mask: bit k set when nibbles k..top are all zero.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (active_digits[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lead_zero[k] = lead_zero[k+1] && (active_digits[4*k +: 4] == 4'h0);
    end
  end

  // Active-high view of the selected digit, before polarity and registering.
  always_comb begin
    sel_nibble = active_digits[4*int'(index) +: 4];
    dark       = active_blank[index] || (lzs_i && (index != '0) && lead_zero[index]);
    seg_next   = dark ? 7'h00 : hex_to_seg(sel_nibble);
    dp_next    = !dark && active_dp[index];
    an_next    = '0;
    an_next[index] = 1'b1;
  end

  // Registered pins, inverted for common-anode parts and held dark in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_o <= {7{COMMON_ANODE}};
      dp_o  <= COMMON_ANODE;
      an_o  <= {NUM_DIGITS{COMMON_ANODE}};
    end else begin
      seg_o <= seg_next ^ {7{COMMON_ANODE}};
      dp_o  <= dp_next ^ COMMON_ANODE;
      an_o  <= an_next ^ {NUM_DIGITS{COMMON_ANODE}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a common-cathode instance with
// NUM_DIGITS=4, CLK_DIV=4 and a common-anode twin for polarity checks.
// cyc counts rising edges since reset release; a frame is 16 clocks.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        load;
  logic        lzs;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame;

  logic        rst2_n;
  logic [15:0] digits2;
  logic        load2;
  logic [3:0]  zero4 = 4'b0000;
  logic        zero1 = 1'b0;
  logic [6:0]  seg2;
  logic        dp_out2;
  logic [3:0]  an2;
  logic        frame2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .COMMON_ANODE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits), .dp_i(dp_in), .blank_i(blank),
    .load_i(load), .lzs_i(lzs), .seg_o(seg), .dp_o(dp_out), .an_o(an), .frame_o(frame)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .rst_n(rst2_n), .digits_i(digits2), .dp_i(zero4), .blank_i(zero4),
    .load_i(load2), .lzs_i(zero1), .seg_o(seg2), .dp_o(dp_out2), .an_o(an2), .frame_o(frame2)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic apply_stimulus(input logic ld, input logic [15:0] d,
                                input logic [3:0] p, input logic [3:0] b);
    load   = ld;
    digits = d;
    dp_in  = p;
    blank  = b;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s at cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic [3:0] exp_an,
                            input logic [6:0] exp_seg, input logic exp_dp);
    check_output({tag, "_an"},  an,     exp_an);
    check_output({tag, "_seg"}, seg,    exp_seg);
    check_output({tag, "_dp"},  dp_out, exp_dp);
  endtask

  initial begin
    logic [3:0] exp_an;
    rst_n   = 1'b0;
    rst2_n  = 1'b0;
    lzs     = 1'b0;
    load2   = 1'b0;
    digits2 = 16'h0000;
    apply_stimulus(1'b0, 16'h0000, 4'h0, 4'h0);
    repeat (3) step();

    check_slot("reset", 4'b0000, 7'h00, 1'b0);
    check_output("reset_frame", frame, 1'b0);
    check_output("ca_reset_seg", seg2, 7'h7F);
    check_output("ca_reset_dp", dp_out2, 1'b1);
    check_output("ca_reset_an", an2, 4'b1111);

    rst_n  = 1'b1;
    rst2_n = 1'b1;
    cyc    = 0;

    for (int i = 1; i <= 32; i++) begin
      step();
      exp_an = 4'b0001 << (((i - 1) / 4) % 4);
      check_slot("walk", exp_an, 7'h3F, 1'b0);
      check_output("walk_frame", frame, (i % 16) == 0);
      if (i == 1) begin
        check_output("ca_old_seg", seg2, 7'h40);
        check_output("ca_old_an", an2, 4'b1110);
      end
      if (i == 2) begin
        load2   = 1'b1;
        digits2 = 16'h0001;
      end
      if (i == 3) load2 = 1'b0;
      if (i == 17) begin
        check_output("ca_seg", seg2, 7'h79);
        check_output("ca_an", an2, 4'b1110);
        check_output("ca_dp", dp_out2, 1'b1);
      end
    end

    goto_cyc(36);
    apply_stimulus(1'b1, 16'h12AF, 4'b0100, 4'b0000);
    step();
    apply_stimulus(1'b0, 16'h12AF, 4'b0100, 4'b0000);
    check_slot("hold_d1", 4'b0010, 7'h3F, 1'b0);
    goto_cyc(45);
    check_slot("hold_d3", 4'b1000, 7'h3F, 1'b0);
    goto_cyc(48);
    check_output("swap_frame", frame, 1'b1);
    goto_cyc(49);
    check_slot("new_d0", 4'b0001, 7'h71, 1'b0);
    goto_cyc(53);
    check_slot("new_d1", 4'b0010, 7'h77, 1'b0);
    goto_cyc(57);
    check_slot("new_d2", 4'b0100, 7'h5B, 1'b1);
    goto_cyc(61);
    check_slot("new_d3", 4'b1000, 7'h06, 1'b0);

    goto_cyc(62);
    lzs = 1'b1;
    apply_stimulus(1'b1, 16'h0050, 4'b1100, 4'b0000);
    step();
    apply_stimulus(1'b0, 16'h0050, 4'b1100, 4'b0000);
    goto_cyc(65);
    check_slot("lzs_d0", 4'b0001, 7'h3F, 1'b0);
    goto_cyc(69);
    check_slot("lzs_d1", 4'b0010, 7'h6D, 1'b0);
    goto_cyc(73);
    check_slot("lzs_d2", 4'b0100, 7'h00, 1'b0);
    goto_cyc(77);
    check_slot("lzs_d3", 4'b1000, 7'h00, 1'b0);
    goto_cyc(80);
    lzs = 1'b0;
    goto_cyc(89);
    check_slot("nolzs_d2", 4'b0100, 7'h3F, 1'b1);
    goto_cyc(93);
    check_slot("nolzs_d3", 4'b1000, 7'h3F, 1'b1);

    goto_cyc(95);
    apply_stimulus(1'b1, 16'h8888, 4'b0000, 4'b0000);
    step();
    apply_stimulus(1'b0, 16'h8888, 4'b0000, 4'b0000);
    check_output("wrapload_frame", frame, 1'b1);
    goto_cyc(97);
    check_slot("wrapload_d0", 4'b0001, 7'h7F, 1'b0);
    check_output("wrapload_pending", dut.pending_valid, 1'b0);
    goto_cyc(101);
    check_slot("wrapload_d1", 4'b0010, 7'h7F, 1'b0);
    goto_cyc(105);
    check_slot("wrapload_d2", 4'b0100, 7'h7F, 1'b0);
    goto_cyc(109);
    check_slot("wrapload_d3", 4'b1000, 7'h7F, 1'b0);

    goto_cyc(110);
    apply_stimulus(1'b1, 16'h8888, 4'b0001, 4'b0010);
    step();
    apply_stimulus(1'b0, 16'h8888, 4'b0001, 4'b0010);
    goto_cyc(113);
    check_slot("blank_d0", 4'b0001, 7'h7F, 1'b1);
    goto_cyc(117);
    check_slot("blank_d1", 4'b0010, 7'h00, 1'b0);

    goto_cyc(118);
    apply_stimulus(1'b1, 16'h1111, 4'b0000, 4'b0000);
    step();
    apply_stimulus(1'b0, 16'h1111, 4'b0000, 4'b0000);
    goto_cyc(120);
    apply_stimulus(1'b1, 16'h2222, 4'b0000, 4'b0000);
    step();
    apply_stimulus(1'b0, 16'h2222, 4'b0000, 4'b0000);
    goto_cyc(124);
    rst_n = 1'b0;
    apply_stimulus(1'b1, 16'h3333, 4'b0000, 4'b0000);
    step();
    check_slot("midreset", 4'b0000, 7'h00, 1'b0);
    check_output("midreset_frame", frame, 1'b0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 16'h3333, 4'b0000, 4'b0000);

    for (int i = 1; i <= 32; i++) begin
      step();
      check_output("after_reset_seg", seg, 7'h3F);
      if (i == 4) check_output("restart_slot_end", an, 4'b0001);
      if (i == 5) check_output("restart_slot_next", an, 4'b0010);
      if (i == 16) check_output("restart_frame", frame, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 Parameter: CLK_DIV, default 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz), legal range 2..2^20.
REQ-003 Parameter: COMMON_ANODE, default 1; 1 = active-low seg_o/dp_o/an_o, 0 = active-high.
REQ-004 Port: clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 Port: rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 Port: digits_i  input  4*NUM_DIGITS  hex nibble per digit; digit k = bits [4k+3:4k]; digit 0 least significant.
REQ-007 Port: dp_i  input  NUM_DIGITS  decimal-point request per digit.
REQ-008 Port: blank_i  input  NUM_DIGITS  force digit k dark when bit k = 1.
REQ-009 Port: load_i  input  1  single-cycle strobe capturing digits_i/dp_i/blank_i.
REQ-010 Port: lzs_i  input  1  leading-zero suppression enable, sampled live.
REQ-011 Port: seg_o  output  7  segments {g,f,e,d,c,b,a}, bit0 = a.
REQ-012 Port: dp_o  output  1  decimal-point segment.
REQ-013 Port: an_o  output  NUM_DIGITS  digit select, exactly one active outside reset.
REQ-014 Port: frame_o  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick = (prescaler == CLK_DIV-1).
REQ-016 On tick, digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0; wrap = tick AND index == NUM_DIGITS-1.
REQ-017 frame_o SHALL be 1 for exactly the cycle after a wrap, else 0.
REQ-018 load_i = 1 SHALL capture inputs into a pending buffer and set pending_valid; a later load before the next wrap overwrites pending.
REQ-019 On wrap with pending_valid = 1, pending SHALL transfer to the active buffer and pending_valid SHALL clear; on wrap with pending_valid = 0, active is unchanged.
REQ-020 load_i coincident with wrap: inputs SHALL go directly to active, pending_valid SHALL end at 0.
REQ-021 Active buffer SHALL never change other than at wrap, so no frame mixes old and new data.
REQ-022 Decode (active-high hex, bit0 = a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-023 Digit k is dark (all segments and dp off) if blank bit k = 1, or if lzs_i = 1, k > 0, and active nibbles k..NUM_DIGITS-1 are all 0.
REQ-024 Digit 0 SHALL never be suppressed by lzs_i.
REQ-025 dp_o SHALL follow active dp bit of the selected digit unless that digit is dark.
REQ-026 seg_o, dp_o, an_o SHALL be registered, reflecting the index one cycle after it changes (latency 1 clk).
REQ-027 COMMON_ANODE = 1 SHALL invert seg_o, dp_o and an_o relative to active-high encoding; frame_o is always active-high.
REQ-028 NUM_DIGITS = 1: index stays 0; every tick is a wrap.

Reset
REQ-029 rst_n = 0 at a rising edge SHALL clear prescaler, index, active and pending buffers, pending_valid and frame_o.
REQ-030 During and after reset until first post-reset update, seg_o/dp_o/an_o SHALL be at inactive level (all 1 if COMMON_ANODE = 1, all 0 otherwise).
REQ-031 Reset asserted mid-frame SHALL discard any pending load; scanning restarts at digit 0 with full CLK_DIV slot.
REQ-032 load_i asserted while rst_n = 0 SHALL be ignored.

Verification (NUM_DIGITS=4, CLK_DIV=4, COMMON_ANODE=0 unless stated)
REQ-033 Reset release, no load -> an_o walks 0001,0010,0100,1000 every 4 clk, seg_o = 3F, frame_o pulses every 16 clk.
REQ-034 Load digits_i=16'h12AF, dp_i=4'b0100 mid-frame -> old value until next frame_o; then seg_o = 71,77,5B,06 for digits 0..3, dp_o = 1 only on digit 2.
REQ-035 Load 16'h0050 with lzs_i=1 -> digits 3,2 dark (seg_o=00, an_o still active), digit 1 = 6D, digit 0 = 3F; lzs_i=0 shows 3F on digits 3,2.
REQ-036 load_i in exact wrap cycle with 16'h8888 -> all digits show 7F in very next frame; pending_valid = 0 afterwards.
REQ-037 Two loads (16'h1111, then 16'h2222) in one frame, then rst_n=0 for 1 clk before wrap -> all digits show 3F, no 06 or 5B ever appears.
REQ-038 COMMON_ANODE=1, digit 0 = 4'h1 -> seg_o = 79 and an_o = 1110 in digit 0 slot; reset holds seg_o=7F, dp_o=1, an_o=1111.
